sram_port_arbiter: RTL and testbench

Shares the single-port generic SRAM bank (addr/wdata/we/ce in, rdata out, fixed read latency) between two requesters. Typical requesters are the axi_sram bank port and a preload/DMA engine. Arbitration is round-robin, with an optional bounded lock for atomic multi-beat sequences. The block tracks in-flight reads through a latency pipeline and routes each read response back to the requester that issued it. It sits between the requesters and generic_memory in the top-level SRAM path.

---
 rtl/sram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port SRAM with bounded lock; grant and mem drive are combinational.
// Read responses return READ_LATENCY cycles after issue, tagged to the issuer; responses cannot be backpressured.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2,
   parameter int LOCK_MAX     = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_req_valid,
   output logic [1:0]              o_req_ready,
   input  logic [1:0]              i_req_lock,
   input  logic [1:0]              i_req_we,
   input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
   output logic [1:0]              o_rsp_valid,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    mem_we,
   output logic                    mem_ce,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   typedef enum logic {IDLE, LOCKED} state_t;

   typedef struct packed {
      logic vld;
      logic id;
   } rd_tag_t;

   // The entry beat counts toward the lock budget, so the last owned cycle sees hold_cnt == LOCK_MAX-1.
   localparam logic [7:0] LAST_HOLD = 8'(LOCK_MAX - 1);

   state_t                        state_q, state_d;
   logic                          rr_q, rr_d;
   logic                          owner_q, owner_d;
   logic [7:0]                    hold_q, hold_d;
   logic [1:0]                    gnt;
   logic                          gnt_any;
   logic                          gnt_idx;
   logic                          rd_issue;
   rd_tag_t [READ_LATENCY-1:0]    pipe_q;
   rd_tag_t                       rsp_tag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b1;
         owner_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      rr_d    = gnt_any ? gnt_idx : rr_q;
      case (state_q)
         IDLE: begin
            if (gnt_any && i_req_lock[gnt_idx]) begin
               state_d = LOCKED;
               owner_d = gnt_idx;
               hold_d  = 8'd1;
            end
         end
         LOCKED: begin
            hold_d = hold_q + 8'd1;
            // Lock dropped ends ownership whether or not the owner moved a beat this cycle.
            if (!i_req_lock[owner_q] || (hold_q == LAST_HOLD)) begin
               state_d = IDLE;
               hold_d  = '0;
               rr_d    = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt = 2'b00;
      if (i_rst_n) begin
         if (state_q == IDLE) begin
            if (&i_req_valid) gnt = rr_q ? 2'b01 : 2'b10;
            else              gnt = i_req_valid;
         end else begin
            gnt = owner_q ? {i_req_valid[1], 1'b0} : {1'b0, i_req_valid[0]};
         end
      end
   end

   assign gnt_any     = |gnt;
   assign gnt_idx     = gnt[1];
   assign o_req_ready = gnt;

   assign mem_ce    = gnt_any;
   assign mem_we    = gnt_any && i_req_we[gnt_idx];
   assign mem_addr  = !gnt_any ? '0 :
                      gnt_idx  ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
   assign mem_wdata = !gnt_any ? '0 :
                      gnt_idx  ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_wdata[DATA_WIDTH-1:0];
   assign rd_issue  = gnt_any && !i_req_we[gnt_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0].vld <= rd_issue;
         pipe_q[0].id  <= gnt_idx;
         for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign rsp_tag     = pipe_q[READ_LATENCY-1];
   assign o_rsp_valid = !rsp_tag.vld ? 2'b00 : (rsp_tag.id ? 2'b10 : 2'b01);
   assign o_rsp_rdata = rsp_tag.vld ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed vector bench for sram_port_arbiter with a 2-cycle-latency SRAM model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  v, lk, we;
   logic [11:0] a0, a1;
   logic [31:0] d0, d1;
   logic [1:0]  rdy, rsp_v;
   logic [31:0] rsp_d;
   logic [11:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_we, m_ce;
   logic [31:0] mem [4096];
   logic [31:0] r1, r2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]  v, lk, we;
      logic [11:0] a0, a1;
      logic [31:0] d0, d1;
      logic [1:0]  rdy, rv;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (v),
      .o_req_ready (rdy),
      .i_req_lock  (lk),
      .i_req_we    (we),
      .i_req_addr  ({a1, a0}),
      .i_req_wdata ({d1, d0}),
      .o_rsp_valid (rsp_v),
      .o_rsp_rdata (rsp_d),
      .mem_addr    (m_addr),
      .mem_wdata   (m_wdata),
      .mem_we      (m_we),
      .mem_ce      (m_ce),
      .mem_rdata   (r2)
   );

   always @(posedge clk) begin
      if (m_ce) begin
         if (m_we) mem[m_addr] <= m_wdata;
         else      r1 <= mem[m_addr];
      end
      r2 <= r1;
   end

   task automatic add(input logic [1:0] tv, tlk, twe, input logic [11:0] ta0, ta1,
                      input logic [31:0] td0, td1, input logic [1:0] trdy, trv, input logic [31:0] trd);
      vec_t t;
      t.v = tv; t.lk = tlk; t.we = twe; t.a0 = ta0; t.a1 = ta1; t.d0 = td0; t.d1 = td1;
      t.rdy = trdy; t.rv = trv; t.rd = trd;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ready"}, 64'(rdy), 64'd0);
      chk({tag, " rsp_valid"}, 64'(rsp_v), 64'd0);
      chk({tag, " rsp_rdata"}, 64'(rsp_d), 64'd0);
      chk({tag, " mem_ce"}, 64'(m_ce), 64'd0);
      chk({tag, " mem_we"}, 64'(m_we), 64'd0);
      chk({tag, " mem_addr"}, 64'(m_addr), 64'd0);
      chk({tag, " mem_wdata"}, 64'(m_wdata), 64'd0);
   endtask

   initial begin
      logic [11:0] ea;
      logic [31:0] ed;
      logic        ewe;

      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[12'h010] = 32'hDEADBEEF;
      r1 = '0; r2 = '0;

      // single read by req0
      add(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 0, 0, 2'b01, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
      add(2'b10, 2'b00, 2'b00, 12'h000, 12'h011, 0, 0, 2'b10, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b00, 0);
      // alternating contention
      add(2'b11, 2'b00, 2'b00, 12'h100, 12'h200, 0, 0, 2'b01, 2'b10, 32'hA0000011);
      add(2'b11, 2'b00, 2'b00, 12'h101, 12'h201, 0, 0, 2'b10, 2'b00, 0);
      add(2'b11, 2'b00, 2'b00, 12'h102, 12'h202, 0, 0, 2'b01, 2'b01, 32'hA0000100);
      add(2'b11, 2'b00, 2'b00, 12'h103, 12'h203, 0, 0, 2'b10, 2'b10, 32'hA0000201);
      add(2'b11, 2'b00, 2'b00, 12'h104, 12'h204, 0, 0, 2'b01, 2'b01, 32'hA0000102);
      add(2'b11, 2'b00, 2'b00, 12'h105, 12'h205, 0, 0, 2'b10, 2'b10, 32'hA0000203);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'hA0000104);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b10, 32'hA0000205);
      // req1 lock held to forced release
      add(2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b01, 2'b00, 0);
      add(2'b11, 2'b10, 2'b00, 12'h300, 12'h400, 0, 0, 2'b10, 2'b00, 0);
      add(2'b11, 2'b10, 2'b00, 12'h300, 12'h401, 0, 0, 2'b10, 2'b01, 32'hA0000000);
      for (int i = 2; i < 8; i++)
         add(2'b11, 2'b10, 2'b00, 12'h300, 12'h400 + 12'(i), 0, 0, 2'b10, 2'b10, 32'hA0000400 + 32'(i - 2));
      add(2'b11, 2'b10, 2'b00, 12'h300, 12'h408, 0, 0, 2'b01, 2'b10, 32'hA0000406);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b10, 32'hA0000407);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'hA0000300);
      // locked write burst by req0, then readback
      add(2'b10, 2'b00, 2'b00, 12'h000, 12'h001, 0, 0, 2'b10, 2'b00, 0);
      add(2'b11, 2'b01, 2'b01, 12'h050, 12'h002, 32'h11111111, 0, 2'b01, 2'b00, 0);
      add(2'b11, 2'b01, 2'b01, 12'h051, 12'h002, 32'h22222222, 0, 2'b01, 2'b10, 32'hA0000001);
      add(2'b11, 2'b00, 2'b01, 12'h052, 12'h002, 32'h33333333, 0, 2'b01, 2'b00, 0);
      add(2'b11, 2'b00, 2'b00, 12'h050, 12'h002, 0, 0, 2'b10, 2'b00, 0);
      add(2'b01, 2'b00, 2'b00, 12'h050, 12'h000, 0, 0, 2'b01, 2'b00, 0);
      add(2'b01, 2'b00, 2'b00, 12'h051, 12'h000, 0, 0, 2'b01, 2'b10, 32'hA0000002);
      add(2'b01, 2'b00, 2'b00, 12'h052, 12'h000, 0, 0, 2'b01, 2'b01, 32'h11111111);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'h22222222);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'h33333333);
      // write by req1 then read of same address by req0
      add(2'b10, 2'b00, 2'b10, 12'h000, 12'h020, 0, 32'h12345678, 2'b10, 2'b00, 0);
      add(2'b01, 2'b00, 2'b00, 12'h020, 12'h000, 0, 0, 2'b01, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b01, 32'h12345678);
      // lock blocks the other side for one cycle, then releases on owner idle
      add(2'b01, 2'b01, 2'b00, 12'h000, 12'h000, 0, 0, 2'b01, 2'b00, 0);
      add(2'b10, 2'b00, 2'b00, 12'h000, 12'h003, 0, 0, 2'b00, 2'b00, 0);
      add(2'b10, 2'b00, 2'b00, 12'h000, 12'h003, 0, 0, 2'b10, 2'b01, 32'hA0000000);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 2'b00, 2'b10, 32'hA0000003);

      rst_n = 1'b0;
      v = 2'b11; lk = 2'b11; we = 2'b00; a0 = 12'h123; a1 = 12'h456; d0 = 32'h1; d1 = 32'h2;
      @(negedge clk);
      #2 chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      v = 2'b00; lk = 2'b00;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         v = vecs[k].v; lk = vecs[k].lk; we = vecs[k].we;
         a0 = vecs[k].a0; a1 = vecs[k].a1; d0 = vecs[k].d0; d1 = vecs[k].d1;
         #2;
         ea  = vecs[k].rdy[0] ? vecs[k].a0 : (vecs[k].rdy[1] ? vecs[k].a1 : 12'h000);
         ed  = vecs[k].rdy[0] ? vecs[k].d0 : (vecs[k].rdy[1] ? vecs[k].d1 : 32'h0);
         ewe = vecs[k].rdy[0] ? vecs[k].we[0] : (vecs[k].rdy[1] ? vecs[k].we[1] : 1'b0);
         chk($sformatf("v%0d ready", k), 64'(rdy), 64'(vecs[k].rdy));
         chk($sformatf("v%0d rsp_valid", k), 64'(rsp_v), 64'(vecs[k].rv));
         chk($sformatf("v%0d rsp_rdata", k), 64'(rsp_d), 64'(vecs[k].rd));
         chk($sformatf("v%0d mem_ce", k), 64'(m_ce), 64'(|vecs[k].rdy));
         chk($sformatf("v%0d mem_we", k), 64'(m_we), 64'(ewe));
         chk($sformatf("v%0d mem_addr", k), 64'(m_addr), 64'(ea));
         chk($sformatf("v%0d mem_wdata", k), 64'(m_wdata), 64'(ed));
      end

      // read in flight with lock, then reset pulse
      @(negedge clk);
      v = 2'b01; lk = 2'b01; we = 2'b00; a0 = 12'h010; a1 = 12'h000; d0 = 0; d1 = 0;
      #2 chk("midrst issue ready", 64'(rdy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      v = 2'b11;
      #2 chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      v = 2'b00; lk = 2'b00;
      for (int c = 0; c < 3; c++) begin
         #2 chk($sformatf("midrst drop c%0d", c), 64'(rsp_v), 64'd0);
         @(negedge clk);
      end
      v = 2'b11; a0 = 12'h100; a1 = 12'h200;
      #2 chk("post-reset contention ready", 64'(rdy), 64'd1);
      @(negedge clk);
      v = 2'b11;
      #2 chk("post-reset unlocked ready", 64'(rdy), 64'd2);
      @(negedge clk);
      v = 2'b00;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
